sound_frame_seq: RTL and testbench



---
 rtl/sound_frame_seq.sv | 95 +++++++++
 tb/tb_sound_frame_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sound_frame_seq.sv
// rtl/sound_frame_seq.sv - APU frame sequencer issuing length/sweep/envelope clock-enable strobes
// Optional macro SOUND_DIV_SYNC_EN: frame events from DIV falling edges instead of the internal prescaler.
module sound_frame_seq #(
  parameter int unsigned PRESCALE = 8192,
  parameter int unsigned PW       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound_enable,
  input  logic       div_bit,
  output logic       frame_tick,
  output logic       tick_len,
  output logic       tick_sweep,
  output logic       tick_env,
  output logic [2:0] step,
  output logic       len_next_clocks
);

  logic [2:0] step_q;
  logic [2:0] step_d;
  logic       frame_tick_q;
  logic       tick_len_q;
  logic       tick_sweep_q;
  logic       tick_env_q;
  logic       event_d;

`ifdef SOUND_DIV_SYNC_EN
  logic div_q;

  // div_q follows DIV even while powered off so a low DIV at power-on is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_bit;
    end
  end

  always_comb begin
    event_d = sound_enable && div_q && !div_bit;
  end
`else
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic          unused_div_bit;

  assign unused_div_bit = div_bit;

  always_comb begin
    event_d = sound_enable && (pcnt_q == PCNT_LAST);
    pcnt_d  = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !sound_enable) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`endif

  always_comb begin
    step_d = step_q + 3'd1;
  end

  // Strobes decode the step being processed; power-off and reset suppress them.
  always_ff @(posedge clk) begin
    if (rst || !sound_enable) begin
      step_q       <= 3'd0;
      frame_tick_q <= 1'b0;
      tick_len_q   <= 1'b0;
      tick_sweep_q <= 1'b0;
      tick_env_q   <= 1'b0;
    end else begin
      frame_tick_q <= event_d;
      tick_len_q   <= event_d && !step_q[0];
      tick_sweep_q <= event_d && (step_q[1:0] == 2'b10);
      tick_env_q   <= event_d && (step_q == 3'd7);
      if (event_d) begin
        step_q <= step_d;
      end
    end
  end

  assign frame_tick      = frame_tick_q;
  assign tick_len        = tick_len_q;
  assign tick_sweep      = tick_sweep_q;
  assign tick_env        = tick_env_q;
  assign step            = step_q;
  assign len_next_clocks = ~step_q[0];

endmodule

// File: tb/tb_sound_frame_seq.sv
// tb/tb_sound_frame_seq.sv - directed table-driven bench for sound_frame_seq with PRESCALE=4
module tb_sound_frame_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       sound_enable;
  logic       div_bit;
  logic       frame_tick;
  logic       tick_len;
  logic       tick_sweep;
  logic       tick_env;
  logic [2:0] step;
  logic       len_next_clocks;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sound_frame_seq #(.PRESCALE(4), .PW(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .sound_enable    (sound_enable),
    .div_bit         (div_bit),
    .frame_tick      (frame_tick),
    .tick_len        (tick_len),
    .tick_sweep      (tick_sweep),
    .tick_env        (tick_env),
    .step            (step),
    .len_next_clocks (len_next_clocks)
  );

  typedef struct {
    logic [2:0] s;
    logic       lnc_s;
    logic       len;
    logic       sweep;
    logic       env;
    logic [2:0] s_next;
    logic       lnc_next;
  } vec_t;

  vec_t vecs [8];

  // Observed word: {frame_tick, tick_len, tick_sweep, tick_env, step, len_next_clocks}
  function automatic logic [7:0] obs();
    return {frame_tick, tick_len, tick_sweep, tick_env, step, len_next_clocks};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Three quiet cycles then the event cycle for one table row.
  task automatic run_event(input int i, input string nm);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk({nm, "_quiet"}, obs(), {4'b0000, vecs[i].s, vecs[i].lnc_s});
    end
    cyc();
    chk({nm, "_event"}, obs(),
        {1'b1, vecs[i].len, vecs[i].sweep, vecs[i].env, vecs[i].s_next, vecs[i].lnc_next});
  endtask

  initial begin
    //          s     lnc  len  sw   env  s_next lnc_next
    vecs[0] = '{3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[1] = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
    vecs[2] = '{3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
    vecs[3] = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[4] = '{3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0};
    vecs[5] = '{3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1};
    vecs[6] = '{3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0};
    vecs[7] = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1};

    rst          = 1'b1;
    sound_enable = 1'b0;
    div_bit      = 1'b0;
    cyc();
    cyc();
    chk("reset", obs(), 8'b0000_000_1);

    rst          = 1'b0;
    sound_enable = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        run_event(i, "frame");
      end
    end

    // Power cycle at step 5, mid-prescale.
    for (int i = 0; i < 5; i++) begin
      run_event(i, "pre_off");
    end
    cyc();
    cyc();
    chk("mid_prescale", obs(), 8'b0000_101_0);
    sound_enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("power_off", obs(), 8'b0000_000_1);
    end

    // Power-off in the cycle pcnt==PRESCALE-1 must suppress the event.
    sound_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("near_wrap", obs(), 8'b0000_000_1);
    end
    sound_enable = 1'b0;
    cyc();
    chk("off_at_wrap", obs(), 8'b0000_000_1);

    sound_enable = 1'b1;
    run_event(0, "re_enable");

    // Reset mid-frame with power on.
    cyc();
    cyc();
    chk("pre_rst", obs(), 8'b0000_001_0);
    rst = 1'b1;
    cyc();
    chk("rst_mid", obs(), 8'b0000_000_1);
    cyc();
    chk("rst_hold", obs(), 8'b0000_000_1);
    rst = 1'b0;
    run_event(0, "post_rst");
    run_event(1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
